// File: rtl/axi_lite_regbank_pkg.sv
// axi_lite_regbank_pkg: response codes and address-decode helpers for the AXI4-Lite register bank
package axi_lite_regbank_pkg;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int addr_lsb(input int dw);
    return clog2(dw / 8);
  endfunction
  function automatic int idx_w(input int aw, input int dw);
    return aw - addr_lsb(dw);
  endfunction
endpackage

// File: rtl/axi_lite_regbank_cell.sv
// axi_lite_regbank_cell: one register with byte-strobe load, RO bypass and W1C set/clear (W1C only with REGBANK_W1C_EN)
module axi_lite_regbank_cell #(
  parameter int DW = 32,
  parameter bit RO = 1'b0,
  parameter bit W1C = 1'b0,
  parameter logic [DW-1:0] RST = '0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [DW/8-1:0] wstrb_i,
  input  logic [DW-1:0] set_i,
  input  logic [DW-1:0] ro_i,
  output logic [DW-1:0] q_o,
  output logic          pend_o
);
`ifdef REGBANK_W1C_EN
  localparam bit W1C_ON = W1C && !RO;
`else
  localparam bit W1C_ON = W1C && 1'b0;
`endif
  logic [DW-1:0] q_q, q_d, bm;
  // expand byte strobes into a bit mask
  always_comb begin
    bm = '0;
    for (int b = 0; b < DW / 8; b++) bm[8*b +: 8] = {8{wstrb_i[b]}};
  end
  // RO holds; W1C clears written ones then ORs in hardware sets (set wins); RW loads strobed bytes
  always_comb begin
    q_d = RO ? q_q : W1C_ON ? ((q_q & ~(we_i ? (wdata_i & bm) : '0)) | set_i) : we_i ? ((q_q & ~bm) | (wdata_i & bm)) : q_q;
    pend_o = W1C_ON && (|q_d);
  end
  // register storage, loads its reset image
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) q_q <= RST;
    else q_q <= q_d;
  assign q_o = RO ? ro_i : q_q;
endmodule

// File: rtl/axi_lite_regbank.sv
// axi_lite_regbank: parametrised AXI4-Lite slave register bank; define REGBANK_W1C_EN for W1C interrupt registers
module axi_lite_regbank import axi_lite_regbank_pkg::*; #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_REGS = 16,
  parameter logic [63:0] RO_MASK = '0,
  parameter logic [63:0] W1C_MASK = '0,
  parameter logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                                   S_AXI_ACLK,
  input  logic                                   S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_in,
  output logic [NUM_REGS-1:0]                    wr_pulse,
`ifdef REGBANK_W1C_EN
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] hw_set,
`endif
  output logic                                   irq
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int ADDR_LSB = addr_lsb(DW);
  localparam int IDXW = idx_w(C_S_AXI_ADDR_WIDTH, DW);
  logic awready_q, arready_q, bvalid_q, rvalid_q, irq_q;
  logic [1:0] bresp_q, rresp_q;
  logic [DW-1:0] rdata_q, rd_val;
  logic [NUM_REGS-1:0] wr_pulse_q, pend;
  logic [DW-1:0] regs [NUM_REGS];
  logic [IDXW-1:0] aw_idx, ar_idx;
  logic aw_ok, ar_ok, unused_ok;
  assign aw_idx = S_AXI_AWADDR[ADDR_LSB +: IDXW];
  assign ar_idx = S_AXI_ARADDR[ADDR_LSB +: IDXW];
  assign aw_ok = int'(aw_idx) < NUM_REGS;
  assign ar_ok = int'(ar_idx) < NUM_REGS;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    axi_lite_regbank_cell #(
      .DW(DW), .RO(RO_MASK[g]), .W1C(W1C_MASK[g]), .RST(RESET_VAL[g*DW +: DW])
    ) u_cell (
      .clk_i(S_AXI_ACLK),
      .rst_ni(S_AXI_ARESETN),
      .we_i(awready_q && aw_ok && aw_idx == IDXW'(g)),
      .wdata_i(S_AXI_WDATA),
      .wstrb_i(S_AXI_WSTRB),
`ifdef REGBANK_W1C_EN
      .set_i(hw_set[g*DW +: DW]),
`else
      .set_i('0),
`endif
      .ro_i(reg_in[g*DW +: DW]),
      .q_o(regs[g]),
      .pend_o(pend[g])
    );
    assign reg_out[g*DW +: DW] = regs[g];
  end
  // read mux; out-of-range indices select nothing and return zero
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) if (ar_idx == IDXW'(i)) rd_val = regs[i];
  end
  // handshake, response and strobe registers; ready pulses one cycle, responses hold until taken
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) begin
      awready_q <= 1'b0;
      arready_q <= 1'b0;
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      bresp_q <= RESP_OKAY;
      rresp_q <= RESP_OKAY;
      rdata_q <= '0;
      wr_pulse_q <= '0;
      irq_q <= 1'b0;
    end else begin
      awready_q <= !awready_q && S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q;
      arready_q <= !arready_q && S_AXI_ARVALID && !rvalid_q;
      wr_pulse_q <= (awready_q && aw_ok) ? NUM_REGS'(1) << aw_idx : '0;
      irq_q <= |pend;
      if (awready_q) begin
        bvalid_q <= 1'b1;
        bresp_q <= aw_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (S_AXI_BREADY) bvalid_q <= 1'b0;
      if (arready_q) begin
        rvalid_q <= 1'b1;
        rresp_q <= ar_ok ? RESP_OKAY : RESP_SLVERR;
        rdata_q <= ar_ok ? rd_val : '0;
      end else if (S_AXI_RREADY) rvalid_q <= 1'b0;
    end
  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY = awready_q;
  assign S_AXI_BVALID = bvalid_q;
  assign S_AXI_BRESP = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID = rvalid_q;
  assign S_AXI_RRESP = rresp_q;
  assign S_AXI_RDATA = rdata_q;
  assign wr_pulse = wr_pulse_q;
  assign irq = irq_q;
endmodule
